// File: rtl/hash_mem_responder.sv
// rtl/hash_mem_responder.sv - RAM responder and host harness for the SHA-256 nonce engine.
// Optional write window check: define HASH_MEM_WRITE_GUARD_EN.
module hash_mem_responder #(
    parameter int DEPTH     = 256,
    parameter int MSG_BASE  = 0,
    parameter int MSG_WORDS = 20,
    parameter int OUT_BASE  = 64,
    parameter int OUT_WORDS = 16,
    parameter int TIMEOUT   = 65535
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        mem_we,
    input  logic [15:0] mem_addr,
    input  logic [31:0] mem_write_data,
    output logic [31:0] mem_read_data,
    output logic        eng_start,
    input  logic        eng_done,
    input  logic        ld_valid,
    output logic        ld_ready,
    input  logic [31:0] ld_data,
    input  logic        go,
    output logic        rd_valid,
    input  logic        rd_ready,
    output logic [31:0] rd_data,
    output logic        busy,
    output logic        error
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [15:0] LAST_LD  = 16'(MSG_WORDS - 1);
    localparam logic [15:0] LAST_RD  = 16'(OUT_WORDS - 1);
    localparam logic [15:0] LAST_CYC = 16'(TIMEOUT - 1);

    typedef enum logic [1:0] {S_LOAD, S_ARMED, S_RUN, S_DRAIN} state_t;

    state_t      state_q, state_d;
    logic [15:0] cnt_q, cnt_d, cyc_q, cyc_d;
    logic [31:0] mem_read_data_q, mem_read_data_d, rd_data_q, rd_data_d;
    logic        ld_ready_q, ld_ready_d, rd_valid_q, rd_valid_d, error_q, error_d;

    logic [31:0]   ram [DEPTH];
    logic          ram_we;
    logic [AW-1:0] ram_waddr, ram_raddr;
    logic [31:0]   ram_wdata, ram_rdata;
    logic          addr_ok, wr_ok, ld_hs, rd_hs;

    always_comb begin
        addr_ok = {16'd0, mem_addr} < 32'(DEPTH);
`ifdef HASH_MEM_WRITE_GUARD_EN
        wr_ok = addr_ok && ({16'd0, mem_addr} >= 32'(OUT_BASE))
                        && ({16'd0, mem_addr} < 32'(OUT_BASE + OUT_WORDS));
`else
        wr_ok = addr_ok;
`endif
        ld_hs = (state_q == S_LOAD) && ld_valid && ld_ready_q;
        rd_hs = rd_valid_q && rd_ready;

        state_d    = state_q;
        cnt_d      = cnt_q;
        cyc_d      = cyc_q;
        rd_valid_d = rd_valid_q;
        rd_data_d  = rd_data_q;
        error_d    = error_q;
        ram_we     = 1'b0;
        ram_waddr  = AW'(mem_addr);
        ram_wdata  = mem_write_data;
        ram_raddr  = AW'(mem_addr);

        case (state_q)
            S_LOAD: begin
                if (ld_hs) begin
                    ram_we    = 1'b1;
                    ram_waddr = AW'(MSG_BASE) + AW'(cnt_q);
                    ram_wdata = ld_data;
                    if (cnt_q == LAST_LD) begin
                        state_d = S_ARMED;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 16'd1;
                    end
                end
            end
            S_ARMED: begin
                if (go) begin
                    state_d = S_RUN;
                    cyc_d   = '0;
                end
            end
            S_RUN: begin
                if (!addr_ok || (mem_we && !wr_ok)) error_d = 1'b1;
                if (mem_we && wr_ok) ram_we = 1'b1;
                if (eng_done) begin
                    state_d = S_DRAIN;
                    cnt_d   = '0;
                end else if (cyc_q == LAST_CYC) begin
                    error_d = 1'b1;
                    state_d = S_LOAD;
                end else begin
                    cyc_d = cyc_q + 16'd1;
                end
            end
            S_DRAIN: begin
                // Prefetch the next word on a handshake so the stream sustains 1 word/cycle.
                ram_raddr = AW'(OUT_BASE) + AW'(rd_hs ? cnt_q + 16'd1 : cnt_q);
                if (rd_hs && cnt_q == LAST_RD) begin
                    state_d    = S_LOAD;
                    cnt_d      = '0;
                    rd_valid_d = 1'b0;
                end else begin
                    rd_data_d  = ram_rdata;
                    rd_valid_d = 1'b1;
                    if (rd_hs) cnt_d = cnt_q + 16'd1;
                end
            end
            default: state_d = S_LOAD;
        endcase

        mem_read_data_d = (state_q == S_DRAIN || !addr_ok) ? 32'd0 : ram_rdata;
        ld_ready_d      = (state_d == S_LOAD) && (cnt_d < 16'(MSG_WORDS));
    end

    assign ram_rdata = ram[ram_raddr];

    always_ff @(posedge clk) begin
        if (ram_we) ram[ram_waddr] <= ram_wdata;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q         <= S_LOAD;
            cnt_q           <= '0;
            cyc_q           <= '0;
            mem_read_data_q <= '0;
            rd_data_q       <= '0;
            ld_ready_q      <= 1'b0;
            rd_valid_q      <= 1'b0;
            error_q         <= 1'b0;
        end else begin
            state_q         <= state_d;
            cnt_q           <= cnt_d;
            cyc_q           <= cyc_d;
            mem_read_data_q <= mem_read_data_d;
            rd_data_q       <= rd_data_d;
            ld_ready_q      <= ld_ready_d;
            rd_valid_q      <= rd_valid_d;
            error_q         <= error_d;
        end
    end

    assign mem_read_data = mem_read_data_q;
    assign rd_data       = rd_data_q;
    assign ld_ready      = ld_ready_q;
    assign rd_valid      = rd_valid_q;
    assign error         = error_q;
    assign eng_start     = (state_q == S_RUN);
    assign busy          = (state_q != S_LOAD);
endmodule

// File: tb/tb_hash_mem_responder.sv
// tb/tb_hash_mem_responder.sv - directed bench for hash_mem_responder (TIMEOUT=100).
module tb_hash_mem_responder;
    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        mem_we = 1'b0;
    logic [15:0] mem_addr = '0;
    logic [31:0] mem_write_data = '0;
    logic [31:0] mem_read_data;
    logic        eng_start;
    logic        eng_done = 1'b0;
    logic        ld_valid = 1'b0;
    logic        ld_ready;
    logic [31:0] ld_data = '0;
    logic        go = 1'b0;
    logic        rd_valid;
    logic        rd_ready = 1'b0;
    logic [31:0] rd_data;
    logic        busy;
    logic        error;

    int total = 0;
    int bad   = 0;

    hash_mem_responder #(.TIMEOUT(100)) dut (
        .clk(clk), .reset_n(reset_n),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_write_data(mem_write_data),
        .mem_read_data(mem_read_data),
        .eng_start(eng_start), .eng_done(eng_done),
        .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_data(ld_data),
        .go(go),
        .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data),
        .busy(busy), .error(error)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_words(input logic [31:0] base);
        ld_valid = 1'b1;
        for (int i = 0; i < 20; i++) begin
            ld_data = base + 32'(i);
            tick();
        end
        ld_valid = 1'b0;
    endtask

    task automatic start_run();
        go = 1'b1;
        tick();
        go = 1'b0;
    endtask

    task automatic eng_write(input logic [15:0] a, input logic [31:0] d);
        mem_addr = a; mem_write_data = d; mem_we = 1'b1;
        tick();
        mem_we = 1'b0;
    endtask

    task automatic eng_read(input logic [15:0] a, output logic [31:0] d);
        mem_addr = a;
        tick();
        d = mem_read_data;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        repeat (2) tick();
        total++;
        if ({mem_read_data, rd_data, eng_start, ld_ready, rd_valid, busy, error} !== 69'd0) begin
            bad++; $display("FAIL reset_outputs got=%h want=0",
                {mem_read_data, rd_data, eng_start, ld_ready, rd_valid, busy, error});
        end
        reset_n = 1'b1;
        tick();
        total++;
        if (ld_ready !== 1'b1) begin bad++; $display("FAIL reset_ld_ready got=%b want=1", ld_ready); end
    endtask

    task automatic test_load_and_read();
        logic [31:0] d;
        ld_valid = 1'b1;
        for (int i = 0; i < 20; i++) begin
            ld_data = 32'(i);
            total++;
            if (ld_ready !== 1'b1) begin bad++; $display("FAIL load_ready[%0d] got=%b want=1", i, ld_ready); end
            tick();
        end
        ld_valid = 1'b0;
        total++;
        if (ld_ready !== 1'b0 || busy !== 1'b1) begin
            bad++; $display("FAIL load_done ready=%b busy=%b want ready=0 busy=1", ld_ready, busy);
        end
        start_run();
        total++;
        if (eng_start !== 1'b1) begin bad++; $display("FAIL go_start got=%b want=1", eng_start); end
        eng_read(16'd5, d);
        total++;
        if (d !== 32'h5) begin bad++; $display("FAIL read_addr5 got=%h want=00000005", d); end
        eng_read(16'd19, d);
        total++;
        if (d !== 32'h13) begin bad++; $display("FAIL read_addr19 got=%h want=00000013", d); end
    endtask

    task automatic test_write_and_drain();
        logic [31:0] d;
        eng_write(16'd64, 32'h1111_1111);
        eng_write(16'd64, 32'hA000_0000);
        total++;
        if (mem_read_data !== 32'h1111_1111) begin
            bad++; $display("FAIL same_edge_read got=%h want=11111111", mem_read_data);
        end
        eng_read(16'd64, d);
        total++;
        if (d !== 32'hA000_0000) begin bad++; $display("FAIL next_edge_read got=%h want=a0000000", d); end
        for (int i = 1; i < 16; i++) eng_write(16'(64 + i), 32'hA000_0000 + 32'(i));
        eng_done = 1'b1;
        tick();
        eng_done = 1'b0;
        total++;
        if (eng_start !== 1'b0 || rd_valid !== 1'b0 || busy !== 1'b1 || error !== 1'b0) begin
            bad++; $display("FAIL enter_drain start=%b valid=%b busy=%b err=%b want 0,0,1,0",
                eng_start, rd_valid, busy, error);
        end
        eng_read(16'd5, d);
        total++;
        if (d !== 32'd0 || rd_valid !== 1'b1) begin
            bad++; $display("FAIL drain_first mem_rd=%h valid=%b want 0 and 1", d, rd_valid);
        end
        rd_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            total++;
            if (rd_valid !== 1'b1 || rd_data !== 32'hA000_0000 + 32'(i)) begin
                bad++; $display("FAIL drain_fast[%0d] valid=%b got=%h want=%h",
                    i, rd_valid, rd_data, 32'hA000_0000 + 32'(i));
            end
            tick();
        end
        rd_ready = 1'b0;
        total++;
        if (rd_valid !== 1'b0 || busy !== 1'b0 || ld_ready !== 1'b1) begin
            bad++; $display("FAIL drain_end valid=%b busy=%b ld_ready=%b want 0,0,1", rd_valid, busy, ld_ready);
        end
    endtask

    task automatic test_oob_and_stall();
        logic [31:0] d;
        logic [31:0] held;
        logic        stalled;
        int          got;
        load_words(32'h0);
        start_run();
`ifdef HASH_MEM_WRITE_GUARD_EN
        eng_write(16'd10, 32'hBAD0_0010);
        total++;
        if (error !== 1'b1) begin bad++; $display("FAIL guard_error got=%b want=1", error); end
        eng_read(16'd10, d);
        total++;
        if (d !== 32'h0000_000A) begin bad++; $display("FAIL guard_drop got=%h want=0000000a", d); end
`else
        total++;
        if (error !== 1'b0) begin bad++; $display("FAIL pre_oob_error got=%b want=0", error); end
`endif
        eng_write(16'd300, 32'hDEAD_BEEF);
        eng_write(16'd320, 32'hDEAD_BEEF);
        eng_read(16'd300, d);
        total++;
        if (d !== 32'd0 || error !== 1'b1) begin
            bad++; $display("FAIL oob got=%h err=%b want 0 and 1", d, error);
        end
        eng_done = 1'b1;
        tick();
        eng_done = 1'b0;
        got = 0; stalled = 1'b0; held = '0;
        for (int c = 0; c < 200 && got < 16; c++) begin
            tick();
            rd_ready = (c % 2 == 0);
            if (rd_valid) begin
                if (stalled) begin
                    total++;
                    if (rd_data !== held) begin
                        bad++; $display("FAIL stall_hold got=%h want=%h", rd_data, held);
                    end
                end
                if (rd_ready) begin
                    total++;
                    if (rd_data !== 32'hA000_0000 + 32'(got)) begin
                        bad++; $display("FAIL drain_stall[%0d] got=%h want=%h",
                            got, rd_data, 32'hA000_0000 + 32'(got));
                    end
                    got++;
                    stalled = 1'b0;
                end else begin
                    held = rd_data;
                    stalled = 1'b1;
                end
            end
        end
        tick();
        rd_ready = 1'b0;
        total++;
        if (got != 16 || rd_valid !== 1'b0 || ld_ready !== 1'b1) begin
            bad++; $display("FAIL stall_end words=%0d valid=%b ld_ready=%b want 16,0,1", got, rd_valid, ld_ready);
        end
    endtask

    task automatic test_timeout();
        int c;
        logic seen_valid;
        test_reset();
        load_words(32'h0);
        start_run();
        c = 0; seen_valid = 1'b0;
        while (eng_start && c < 300) begin
            tick();
            c++;
            if (rd_valid) seen_valid = 1'b1;
        end
        repeat (3) begin
            tick();
            if (rd_valid) seen_valid = 1'b1;
        end
        total++;
        if (c != 100) begin bad++; $display("FAIL timeout_cycles got=%0d want=100", c); end
        total++;
        if (error !== 1'b1 || ld_ready !== 1'b1 || busy !== 1'b0 || seen_valid !== 1'b0) begin
            bad++; $display("FAIL timeout_state err=%b ld_ready=%b busy=%b rd_valid_seen=%b want 1,1,0,0",
                error, ld_ready, busy, seen_valid);
        end
    endtask

    task automatic test_reset_mid_drain();
        logic [31:0] d;
        test_reset();
        load_words(32'h100);
        start_run();
        eng_done = 1'b1;
        tick();
        eng_done = 1'b0;
        tick();
        rd_ready = 1'b1;
        repeat (3) tick();
        total++;
        if (rd_data !== 32'hA000_0003) begin bad++; $display("FAIL pre_abort got=%h want=a0000003", rd_data); end
        reset_n = 1'b0;
        rd_ready = 1'b0;
        #1;
        total++;
        if ({mem_read_data, rd_data, eng_start, ld_ready, rd_valid, busy, error} !== 69'd0) begin
            bad++; $display("FAIL abort_outputs got=%h want=0",
                {mem_read_data, rd_data, eng_start, ld_ready, rd_valid, busy, error});
        end
        tick();
        reset_n = 1'b1;
        tick();
        total++;
        if (ld_ready !== 1'b1) begin bad++; $display("FAIL abort_ld_ready got=%b want=1", ld_ready); end
        load_words(32'h100);
        start_run();
        eng_read(16'd5, d);
        total++;
        if (d !== 32'h105) begin bad++; $display("FAIL reload_addr5 got=%h want=00000105", d); end
        eng_read(16'd64, d);
        total++;
        if (d !== 32'hA000_0000) begin bad++; $display("FAIL persist64 got=%h want=a0000000", d); end
        eng_read(16'd79, d);
        total++;
        if (d !== 32'hA000_000F) begin bad++; $display("FAIL persist79 got=%h want=a000000f", d); end
    endtask

    initial begin
        test_reset();
        test_load_and_read();
        test_write_and_drain();
        test_oob_and_stall();
        test_timeout();
        test_reset_mid_drain();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/hash_mem_responder.md
# hash_mem_responder

Memory-side responder and host harness for the SHA-256 nonce hash engine. Answers the engine's single-port word memory interface (`mem_we`, `mem_addr`, `mem_write_data`, `mem_read_data`) from an internal RAM. Provides a host streaming port that loads the message words, starts the engine, and drains the result words. It sits between the host/testbench and the hash engine and owns the engine's backing storage.

## Interface
Parameters:
- `DEPTH`, 256: RAM words; valid addresses are 0..DEPTH-1.
- `MSG_BASE`, 0: first message word address.
- `MSG_WORDS`, 20: message words loaded per run.
- `OUT_BASE`, 64: first result word address.
- `OUT_WORDS`, 16: result words drained per run (one per nonce).
- `TIMEOUT`, 65535: maximum number of RUN cycles before abort.

Ports:
- `clk` in 1: single clock; the engine's `mem_clk` equals this clock.
- `reset_n` in 1: asynchronous, active-low reset.
- `mem_we` in 1: engine write enable.
- `mem_addr` in 16: engine word address.
- `mem_write_data` in 32: engine write data.
- `mem_read_data` out 32: registered read data to the engine.
- `eng_start` out 1: engine start level.
- `eng_done` in 1: engine done level.
- `ld_valid` in 1, `ld_ready` out 1, `ld_data` in 32: message load stream.
- `go` in 1: run request.
- `rd_valid` out 1, `rd_ready` in 1, `rd_data` out 32: result drain stream.
- `busy` out 1: high in ARMED, RUN and DRAIN.
- `error` out 1: sticky flag for out-of-range engine access or timeout. Cleared only by reset.

## Operation
- FSM states: LOAD → ARMED → RUN → DRAIN → LOAD.
- LOAD:
  - `ld_ready`=1 while load count < MSG_WORDS.
  - Each `ld_valid&&ld_ready` writes `ld_data` to MSG_BASE+count.
  - After word MSG_WORDS-1 is accepted, go to ARMED and clear the count.
- ARMED: wait for `go`=1, then go to RUN and clear the cycle counter.
- RUN:
  - `eng_start`=1 (level) for the whole state.
  - Engine reads: `mem_read_data` ← RAM[`mem_addr`] every edge.
  - Engine writes: when `mem_we`=1, RAM[`mem_addr`] ← `mem_write_data`.
  - On `eng_done`=1, drop `eng_start` and go to DRAIN.
  - When the cycle counter reaches TIMEOUT, set `error`, drop `eng_start` and go to LOAD without draining.
- DRAIN:
  - Stream RAM[OUT_BASE+i] for i=0..OUT_WORDS-1 over the rd port.
  - Internal read address is i+1 on the handshake cycle, otherwise i, so back-to-back transfers run at 1 word/cycle.
  - After the handshake for i=OUT_WORDS-1, go to LOAD.
- Engine port outside RUN:
  - `mem_we` is ignored.
  - `mem_read_data` still returns RAM[`mem_addr`], except in DRAIN, where it returns 0 because the RAM port is owned by the drain.
- Out-of-range address (`mem_addr` ≥ DEPTH) in RUN:
  - A read returns 0.
  - A write is dropped.
  - `error` is set.
- `rd_data` holds its value while `rd_valid&&!rd_ready`.
- `go` outside ARMED is ignored. `ld_valid` outside LOAD is ignored.
- RAM contents are not reset and persist across runs.

## Timing
- Reset values:
  - `mem_read_data`=0, `eng_start`=0, `ld_ready`=0, `rd_valid`=0, `rd_data`=0, `busy`=0, `error`=0.
  - State is LOAD with count 0.
  - `ld_ready` rises on the first edge after `reset_n` deasserts.
- Read latency to the engine: address sampled at edge N, data valid after edge N, usable at edge N+1.
- A write in RUN is visible to an engine read of the same address issued on the following edge; a same-edge read returns the old data.
- LOAD→ARMED takes effect on the edge of the last accepted word; `ld_ready`=0 from the next cycle.
- `go` at edge N: `eng_start`=1 after edge N.
- `eng_done` sampled at edge N: `eng_start`=0 and state DRAIN after edge N.
- First `rd_valid`=1 one cycle after entering DRAIN.
- A `reset_n` assertion mid-run aborts at once: all outputs return to reset values and RAM is untouched.

## Configuration
- Macro `HASH_MEM_WRITE_GUARD_EN`.
- Defined: in RUN, engine writes outside [OUT_BASE, OUT_BASE+OUT_WORDS) are dropped and set `error`.
- Undefined: every in-range write in RUN is accepted, and `error` is set only by out-of-range accesses or timeout.

## Test plan
- Reset, then load 20 words 0x00000000..0x00000013 with `ld_valid` held high → `ld_ready` drops after the 20th word; an engine-model read of address 5 in RUN returns 0x00000005 one cycle after the address.
- `go` pulse, engine model writes 0xA0000000+i to 64+i for i=0..15, then raises `eng_done` → drain emits 0xA0000000..0xA000000F in order at 1 word/cycle with `rd_ready`=1.
- Drain with `rd_ready` toggling 1,0,1,0 → `rd_data` stable while stalled; no word lost or duplicated; state LOAD after the 16th handshake.
- In RUN, engine write to address 300 and read of address 300 → read returns 0, `error`=1, RAM unchanged. With the guard macro defined, a write to address 10 → dropped and `error`=1.
- TIMEOUT=100 with `eng_done` never asserted → `eng_start` falls after 100 RUN cycles, `error`=1, state LOAD, `rd_valid` never asserted.
- `reset_n` asserted in DRAIN after 3 words → all outputs 0 at once; after release, `ld_ready`=1 and RAM still holds the result words.
